vending_machine_param: RTL and testbench

- Parametrised successor to the single-input ticket vending FSM.
- Accepts coins of three denominations into a credit register and vends at a configurable price.
- Returns change, or a cancelled credit, as one pulse per coin unit, and rejects invalid or overflowing coins.
- Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_param_if.sv | 39 +++
 rtl/vending_machine_param.sv | 150 +++++++++++++++
 tb/tb_vending_machine_param.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_machine_param_if.sv
// Coin-acceptor / dispenser bundle for vending_machine_param.
// master = front end and drivers, slave = the vending machine.
interface vending_machine_param_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                change_pulse;
    logic                coin_reject;
    logic                busy;
    logic                sold_out;

    modport master (
        output coin_valid,
        output coin_code,
        output cancel,
        input  credit,
        input  dispense,
        input  change_pulse,
        input  coin_reject,
        input  busy,
        input  sold_out
    );

    modport slave (
        input  coin_valid,
        input  coin_code,
        input  cancel,
        output credit,
        output dispense,
        output change_pulse,
        output coin_reject,
        output busy,
        output sold_out
    );
endinterface

// File: rtl/vending_machine_param.sv
// Coin-credit vending FSM: vends at PRICE, returns change one unit per pulse.
// Define VENDING_STOCK_COUNT_EN to add a stock counter driving sold_out.
module vending_machine_param #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 10,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    vending_machine_param_if.slave bus
);
    localparam int SW = CREDIT_W + 1;
    localparam logic [SW-1:0] PRICE_X = SW'(PRICE);
    localparam logic [SW-1:0] MAX_X   = SW'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE
    } state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic                dispense_q;
    logic                change_q;
    logic                reject_q;
    logic                busy_q;

    logic [SW-1:0] value;
    logic [SW-1:0] sum;
    logic [SW-1:0] rem;
    logic          open_st;
    logic          accept;
    logic          blocked;

    always_comb begin
        value = '0;
        unique case (1'b1)
            (bus.coin_code == 2'd0): value = SW'(1);
            (bus.coin_code == 2'd1): value = SW'(2);
            (bus.coin_code == 2'd2): value = SW'(5);
            (bus.coin_code == 2'd3): value = '0;
        endcase
    end

    // One bit wider than credit so neither the add nor the subtract wraps
    assign sum     = {1'b0, credit_q} + value;
    assign rem     = {1'b0, credit_q} - PRICE_X;
    assign open_st = (state == ST_IDLE) || (state == ST_CREDIT);
    assign accept  = bus.coin_valid
                  && (bus.coin_code != 2'd3)
                  && open_st
                  && !bus.cancel
                  && (sum <= MAX_X)
                  && !blocked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            busy_q     <= 1'b0;
            reject_q   <= bus.coin_valid && !accept;
            unique case (state)
                ST_IDLE, ST_CREDIT: begin
                    if (accept) begin
                        credit_q <= sum[CREDIT_W-1:0];
                        if (sum >= PRICE_X) begin
                            state      <= ST_VEND;
                            dispense_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            state <= ST_CREDIT;
                        end
                    end else if ((state == ST_CREDIT) && bus.cancel) begin
                        state    <= ST_CHANGE;
                        change_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_VEND: begin
                    credit_q <= rem[CREDIT_W-1:0];
                    if (rem != '0) begin
                        state    <= ST_CHANGE;
                        change_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    // Last owed unit is being paid in this cycle
                    if (credit_q <= CREDIT_W'(1)) begin
                        state    <= ST_IDLE;
                        credit_q <= '0;
                    end else begin
                        credit_q <= credit_q - CREDIT_W'(1);
                        change_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    credit_q <= '0;
                end
            endcase
        end
    end

`ifdef VENDING_STOCK_COUNT_EN
    logic [STOCK_W-1:0] stock;
    logic               sold_q;

    // Stock is taken when the vend cycle completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stock  <= STOCK_W'(STOCK_INIT);
            sold_q <= (STOCK_INIT == 0);
        end else if ((state == ST_VEND) && (stock != '0)) begin
            stock  <= stock - STOCK_W'(1);
            sold_q <= (stock == STOCK_W'(1));
        end
    end

    assign blocked      = sold_q;
    assign bus.sold_out = sold_q;
`else
    logic unused_cfg;

    assign unused_cfg   = ^{32'(STOCK_W), 32'(STOCK_INIT)};
    assign blocked      = 1'b0;
    assign bus.sold_out = 1'b0;
`endif

    assign bus.credit       = credit_q;
    assign bus.dispense     = dispense_q;
    assign bus.change_pulse = change_q;
    assign bus.coin_reject  = reject_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed plan steps then random coins,
// checked every cycle against a timeline model of expected output cycles.
module tb_vending_machine_param;
    localparam int PRICE = 3;
    localparam int MAXC  = 10;
    localparam int CW    = 4;
    localparam int STW   = 4;
`ifdef VENDING_STOCK_COUNT_EN
    localparam int  SINIT = 1;
    localparam bit  FEAT  = 1'b1;
`else
    localparam int  SINIT = 8;
    localparam bit  FEAT  = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    vending_machine_param_if #(.CREDIT_W(CW)) vif ();

    vending_machine_param #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAXC),
        .CREDIT_W   (CW),
        .STOCK_W    (STW),
        .STOCK_INIT (SINIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each entry is one future busy cycle: vend or a change unit
    typedef struct {
        bit d;
        bit c;
        int cr;
    } ent_t;

    ent_t q[$];
    int   m_cr;
    bit   m_busy;
    bit   m_vend_now;
    int   m_stock;
    bit   e_disp;
    bit   e_chg;
    bit   e_rej;
    bit   e_busy;
    bit   e_sold;
    int   e_cr;

    function automatic int coin_val(input logic [1:0] c);
        case (c)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 5;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cr       = 0;
        m_busy     = 1'b0;
        m_vend_now = 1'b0;
        m_stock    = SINIT;
        e_disp     = 1'b0;
        e_chg      = 1'b0;
        e_rej      = 1'b0;
        e_busy     = 1'b0;
        e_cr       = 0;
        e_sold     = FEAT && (SINIT == 0);
    endtask

    task automatic model_edge();
        int   v;
        bit   acc;
        ent_t e;
        v   = coin_val(vif.coin_code);
        acc = vif.coin_valid && (vif.coin_code != 2'd3) && !m_busy
           && !vif.cancel && (m_cr + v <= MAXC) && !e_sold;
        e_rej = vif.coin_valid && !acc;
        if (acc) begin
            m_cr += v;
            if (m_cr >= PRICE) begin
                q.push_back('{d: 1'b1, c: 1'b0, cr: m_cr});
                for (int k = m_cr - PRICE; k > 0; k--)
                    q.push_back('{d: 1'b0, c: 1'b1, cr: k});
                m_cr = 0;
            end
        end else if (vif.cancel && !m_busy && m_cr > 0) begin
            for (int k = m_cr; k > 0; k--)
                q.push_back('{d: 1'b0, c: 1'b1, cr: k});
            m_cr = 0;
        end
        if (m_vend_now && m_stock > 0)
            m_stock--;
        e_sold = FEAT && (m_stock == 0);
        if (q.size() > 0) begin
            e      = q.pop_front();
            e_disp = e.d;
            e_chg  = e.c;
            e_cr   = e.cr;
            m_busy = 1'b1;
        end else begin
            e_disp = 1'b0;
            e_chg  = 1'b0;
            e_cr   = m_cr;
            m_busy = 1'b0;
        end
        e_busy     = m_busy;
        m_vend_now = e_disp;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".credit"},   32'(vif.credit),       32'(e_cr));
        chk({tag, ".dispense"}, 32'(vif.dispense),     32'(e_disp));
        chk({tag, ".change"},   32'(vif.change_pulse), 32'(e_chg));
        chk({tag, ".reject"},   32'(vif.coin_reject),  32'(e_rej));
        chk({tag, ".busy"},     32'(vif.busy),         32'(e_busy));
        chk({tag, ".sold"},     32'(vif.sold_out),     32'(e_sold));
    endtask

    task automatic step(input string tag, input logic v,
                        input logic [1:0] c, input logic k);
        vif.coin_valid = v;
        vif.coin_code  = c;
        vif.cancel     = k;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        vif.coin_valid = 1'b0;
        vif.cancel     = 1'b0;
    endtask

    initial begin
        int pulses;
        int vends;
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        vif.coin_valid = 1'b0;
        vif.coin_code  = 2'd0;
        vif.cancel     = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b1;

        // three single-unit coins reach the price exactly
        step("tp1_c1", 1'b1, 2'd0, 1'b0);
        step("tp1_i1", 1'b0, 2'd0, 1'b0);
        step("tp1_c2", 1'b1, 2'd0, 1'b0);
        chk("tp1_credit2", 32'(vif.credit), 32'd2);
        step("tp1_i2", 1'b0, 2'd0, 1'b0);
        step("tp1_c3", 1'b1, 2'd0, 1'b0);
        chk("tp1_vend", 32'(vif.dispense), 32'd1);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step("tp1_tail", 1'b0, 2'd0, 1'b0);
            pulses += int'(vif.change_pulse);
        end
        chk("tp1_pulses", 32'(pulses), 32'd0);

        // five units: vend then two change pulses
        step("tp2_c", 1'b1, 2'd2, 1'b0);
        chk("tp2_vend", 32'(vif.dispense), 32'd1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step("tp2_tail", 1'b0, 2'd0, 1'b0);
            pulses += int'(vif.change_pulse);
        end
        chk("tp2_pulses", 32'(pulses), 32'd2);

        // two units then cancel: refund without vend
        step("tp3_c", 1'b1, 2'd1, 1'b0);
        step("tp3_x", 1'b0, 2'd0, 1'b1);
        pulses = int'(vif.change_pulse);
        vends  = 0;
        for (int i = 0; i < 3; i++) begin
            step("tp3_tail", 1'b0, 2'd0, 1'b0);
            pulses += int'(vif.change_pulse);
            vends  += int'(vif.dispense);
        end
        chk("tp3_pulses", 32'(pulses), 32'd2);
        chk("tp3_vends", 32'(vends), 32'd0);

        // slug, coin during change, coin with cancel
        step("tp4_slug", 1'b1, 2'd3, 1'b0);
        chk("tp4_slug_rej", 32'(vif.coin_reject), 32'd1);
        step("tp4_i", 1'b0, 2'd0, 1'b0);
        step("tp4_c5", 1'b1, 2'd2, 1'b0);
        step("tp4_vend", 1'b0, 2'd0, 1'b0);
        step("tp4_inchg", 1'b1, 2'd0, 1'b0);
        chk("tp4_chg_rej", 32'(vif.coin_reject), 32'd1);
        for (int i = 0; i < 2; i++)
            step("tp4_tail", 1'b0, 2'd0, 1'b0);
        step("tp4_c1", 1'b1, 2'd0, 1'b0);
        step("tp4_both", 1'b1, 2'd1, 1'b1);
        chk("tp4_both_rej", 32'(vif.coin_reject), 32'd1);
        chk("tp4_both_chg", 32'(vif.change_pulse), 32'd1);
        for (int i = 0; i < 2; i++)
            step("tp4_tail2", 1'b0, 2'd0, 1'b0);

        // reset in the second change cycle drops everything at once
        step("tp5_c5", 1'b1, 2'd2, 1'b0);
        step("tp5_vend", 1'b0, 2'd0, 1'b0);
        step("tp5_chg1", 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("tp5_async");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            step("tp5_after", 1'b0, 2'd0, 1'b0);

        // with the stock counter at one item, the second buyer is refused
        step("tp6_c5", 1'b1, 2'd2, 1'b0);
        chk("tp6_vend", 32'(vif.dispense), 32'd1);
        for (int i = 0; i < 4; i++)
            step("tp6_tail", 1'b0, 2'd0, 1'b0);
        step("tp6_c1", 1'b1, 2'd0, 1'b0);
        chk("tp6_rej", 32'(vif.coin_reject), 32'(FEAT));

        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 9) < 4),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
